mfcc_melbank_accum: RTL and testbench
=====================================

MFCC_MELBANK_ACCUM -- requirements
Module: mfcc_melbank_accum

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: log2 of spectrum bins per frame; it is also the melbank ROM address width.
REQ-002 SHALL have parameter PWR_WIDTH, default 32: unsigned power-spectrum sample width.
REQ-003 SHALL have parameter COEF_WIDTH, default 16: unsigned melbank weight width, equal to the ROM DATA_WIDTH.
REQ-004 SHALL have parameter ACC_WIDTH, default 56: accumulator and result width; must be at least PWR_WIDTH+COEF_WIDTH+ADDR_WIDTH.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port pwr_valid, input, 1 bit: power sample valid.
REQ-008 SHALL have port pwr_data, input, PWR_WIDTH bits: power sample of the current bin.
REQ-009 SHALL have port pwr_last, input, 1 bit: marks the final bin of the frame.
REQ-010 SHALL have port pwr_ready, output, 1 bit: block accepts a sample.
REQ-011 SHALL have port rom_addr, output, ADDR_WIDTH bits: melbank ROM address.
REQ-012 SHALL have port rom_data, input, COEF_WIDTH bits: ROM weight; the ROM uses a registered output (1-cycle latency) and shares clk/rst.
REQ-013 SHALL have port mel_valid, output, 1 bit: mel energy valid.
REQ-014 SHALL have port mel_data, output, ACC_WIDTH bits: mel filter energy.
REQ-015 SHALL have port mel_ready, input, 1 bit: downstream (log/DCT) accepts the energy.
REQ-016 SHALL have port frame_err, output, 1 bit: one-cycle pulse flagging a frame-length mismatch.

Function
REQ-017 A beat SHALL be accepted on a rising edge with pwr_valid && pwr_ready.
REQ-018 rom_addr SHALL equal bin counter bin_cnt combinationally; bin_cnt SHALL increment on each accepted beat.
REQ-019 bin_cnt SHALL return to 0 on any frame end.
REQ-020 Frame end SHALL be an accepted beat with pwr_last=1 or with bin_cnt = 2**ADDR_WIDTH-1, whichever occurs first.
REQ-021 Pipeline stage 1: at the accept edge k, register pwr_data together with the valid and end-of-frame flags; the ROM registers its weight on the same edge.
REQ-022 Pipeline stage 2: at edge k+1, register prod = pwr_d * rom_data as a full-width unsigned product.
REQ-023 Pipeline stage 3: at edge k+2, set acc <= acc + prod with unsigned arithmetic and no truncation.
REQ-024 FSM states SHALL be IDLE, ACC, FLUSH and OUT.
REQ-025 IDLE->ACC SHALL occur on the first edge after rst deasserts.
REQ-026 ACC->FLUSH SHALL occur on an accepted frame-end beat.
REQ-027 FLUSH SHALL last exactly 2 cycles, then go to OUT.
REQ-028 OUT->ACC SHALL occur on the edge with mel_valid && mel_ready.
REQ-029 pwr_ready SHALL be 1 only in ACC, so no beat is accepted during FLUSH or OUT.
REQ-030 On the edge entering OUT (edge k+2 for frame-end edge k), mel_data SHALL load acc+prod, mel_valid SHALL rise, and acc SHALL clear to 0.
REQ-031 mel_data and mel_valid SHALL be held stable while mel_valid=1 and mel_ready=0.
REQ-032 mel_valid SHALL fall on the edge after the handshake; pwr_ready SHALL be 1 in the following cycle.
REQ-033 mel_ready asserted while mel_valid=0 SHALL have no effect.
REQ-034 frame_err SHALL pulse for one cycle, on the edge after acceptance, when pwr_last=1 with bin_cnt != 2**ADDR_WIDTH-1.
REQ-035 frame_err SHALL also pulse when bin_cnt = 2**ADDR_WIDTH-1 with pwr_last=0.
REQ-036 The frame SHALL still complete normally in both frame_err cases.
REQ-037 pwr_valid=0 gaps inside a frame SHALL stall bin_cnt, with no effect on the result.

Reset
REQ-038 While rst=1, state SHALL be IDLE.
REQ-039 While rst=1, bin_cnt, acc, prod, the pipeline valid/flag registers and mel_data SHALL be 0.
REQ-040 While rst=1, mel_valid, pwr_ready and frame_err SHALL be 0, and rom_addr SHALL be 0.
REQ-041 A reset mid-frame or mid-OUT SHALL discard the partial frame; the next frame SHALL start at bin 0 with acc=0.

Verification (ADDR_WIDTH=4, 16 bins, ROM loaded per scenario)
REQ-042 Weights all 1, pwr_data=1 for 16 beats, last on beat 16 -> mel_valid rises 2 edges after the last accept, mel_data=16, frame_err=0.
REQ-043 Weights w[i]=i, pwr_data=2 constant -> mel_data=240; rom_addr sequence 0..15 observed on the accepts.
REQ-044 mel_ready held 0 for 5 cycles after mel_valid -> mel_data stable at its value and pwr_ready=0 throughout; the handshake then gives pwr_ready=1 one cycle later.
REQ-045 pwr_last on beat 10 (bin 9), weights 1, pwr=3 -> frame_err pulse, mel_data=30; the next frame starts at rom_addr=0.
REQ-046 Reset asserted after 7 beats, then a clean frame with pwr=1 and weights 1 -> all outputs 0 during reset, and the next result is 16 (no residue).
REQ-047 pwr_data all ones and weights all ones for 16 bins, with random pwr_valid gaps -> mel_data = 16*(2^32-1)*(2^16-1), exact.

Source files
------------

// File: rtl/mfcc_melbank_accum.sv
// Mel filterbank accumulator: weights each power-spectrum bin by a melbank ROM
// coefficient and sums the frame into one energy, handed off with valid/ready.
module mfcc_melbank_accum #(
  parameter int ADDR_WIDTH = 8,
  parameter int PWR_WIDTH  = 32,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwr_valid,
  input  logic [PWR_WIDTH-1:0]  pwr_data,
  input  logic                  pwr_last,
  output logic                  pwr_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COEF_WIDTH-1:0] rom_data,
  output logic                  mel_valid,
  output logic [ACC_WIDTH-1:0]  mel_data,
  input  logic                  mel_ready,
  output logic                  frame_err
);

  localparam int PROD_WIDTH = PWR_WIDTH + COEF_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BIN_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, OUT} state_t;

  state_t                  state, state_nxt;
  logic                    flush_cnt;
  logic [ADDR_WIDTH-1:0]   bin_cnt;
  logic [PWR_WIDTH-1:0]    pwr_d;
  logic [1:0]              vld_pipe, eof_pipe;
  logic [PROD_WIDTH-1:0]   prod, prod_full;
  logic [ACC_WIDTH-1:0]    acc, acc_sum;
  logic                    accept, at_max, frame_end;

  assign pwr_ready = (state == ACC);
  assign accept    = pwr_valid && pwr_ready;
  assign at_max    = (bin_cnt == BIN_MAX);
  assign frame_end = accept && (pwr_last || at_max);
  assign rom_addr  = bin_cnt;
  assign prod_full = {{COEF_WIDTH{1'b0}}, pwr_d} * {{PWR_WIDTH{1'b0}}, rom_data};
  assign acc_sum   = acc + ACC_WIDTH'(prod);

  // FLUSH covers the two pipeline stages between the last accept and the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ACC;
      ACC:     if (frame_end) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt) state_nxt = OUT;
      OUT:     if (mel_valid && mel_ready) state_nxt = ACC;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt   <= '0;
      pwr_d     <= '0;
      vld_pipe  <= '0;
      eof_pipe  <= '0;
      prod      <= '0;
      acc       <= '0;
      mel_data  <= '0;
      mel_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // a short frame or a missing last marker both count as a length mismatch
      frame_err <= accept && (pwr_last != at_max);
      if (accept) begin
        bin_cnt <= frame_end ? '0 : bin_cnt + ADDR_WIDTH'(1);
        pwr_d   <= pwr_data;
      end
      vld_pipe <= {vld_pipe[0], accept};
      eof_pipe <= {eof_pipe[0], frame_end};
      prod     <= vld_pipe[0] ? prod_full : '0;
      if (eof_pipe[1]) begin
        mel_data  <= acc_sum;
        mel_valid <= 1'b1;
        acc       <= '0;
      end else begin
        if (vld_pipe[1]) acc <= acc_sum;
        if (mel_valid && mel_ready) mel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mfcc_melbank_accum.sv
// Directed bench for mfcc_melbank_accum: a frame-level sum-of-products model checked
// every cycle, plus literal results per scenario.
module tb_mfcc_melbank_accum;
  localparam int AW = 4, PW = 32, CW = 16, AccW = 56, NB = 16;

  logic clk = 0, rst = 1, pwr_valid = 0, pwr_last = 0, mel_ready = 1;
  logic [PW-1:0]   pwr_data = '0;
  logic            pwr_ready, mel_valid, frame_err;
  logic [AW-1:0]   rom_addr;
  logic [CW-1:0]   rom_data;
  logic [AccW-1:0] mel_data;
  logic [CW-1:0]   rom_mem [NB];

  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  mfcc_melbank_accum #(.ADDR_WIDTH(AW), .PWR_WIDTH(PW), .COEF_WIDTH(CW), .ACC_WIDTH(AccW)) dut (
    .clk(clk), .rst(rst), .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_last(pwr_last),
    .pwr_ready(pwr_ready), .rom_addr(rom_addr), .rom_data(rom_data), .mel_valid(mel_valid),
    .mel_data(mel_data), .mel_ready(mel_ready), .frame_err(frame_err));

  // melbank ROM with registered output
  always @(posedge clk or posedge rst)
    if (rst) rom_data <= '0;
    else     rom_data <= rom_mem[rom_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // frame-level model: sum of pwr*weight over accepted beats, result due 2 edges after frame end
  logic [AccW-1:0] acc_m = '0;
  logic [AccW-1:0] exp_q[$], got_q[$], mdl_q[$];
  int  addr_log[$];
  int  bin_m = 0, cd = 0, since_rst = 0, ferr_cnt = 0;
  bit  busy = 0, exp_mv = 0, ferr_next = 0;

  always @(negedge clk) begin
    bit exp_rdy, acc_now, fend;
    if (rst) begin
      chk("rst_pwr_ready", pwr_ready, 0);
      chk("rst_mel_valid", mel_valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_mel_data", mel_data, 0);
      acc_m = '0; bin_m = 0; busy = 0; exp_mv = 0; ferr_next = 0; cd = 0; since_rst = 0;
      exp_q.delete();
    end else begin
      if (cd > 0) begin cd--; if (cd == 0) exp_mv = 1; end
      exp_rdy = (since_rst > 0) && !busy;
      chk("pwr_ready", pwr_ready, exp_rdy);
      chk("mel_valid", mel_valid, exp_mv);
      chk("frame_err", frame_err, ferr_next);
      chk("rom_addr", rom_addr, bin_m);
      if (exp_mv && exp_q.size() > 0) chk("mel_data", mel_data, exp_q[0]);
      if (frame_err) ferr_cnt++;
      acc_now   = pwr_valid && exp_rdy;
      ferr_next = 0;
      if (acc_now) begin
        addr_log.push_back(int'(rom_addr));
        acc_m += AccW'(pwr_data) * AccW'(rom_mem[bin_m]);
        fend      = pwr_last || (bin_m == NB-1);
        ferr_next = pwr_last != (bin_m == NB-1);
        if (fend) begin
          exp_q.push_back(acc_m);
          acc_m = '0; bin_m = 0; busy = 1; cd = 3;
        end else bin_m++;
      end
      if (exp_mv && mel_ready) begin
        got_q.push_back(mel_data);
        mdl_q.push_back(exp_q.size() > 0 ? exp_q[0] : '0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_mv = 0; busy = 0;
      end
      if (since_rst < 2) since_rst++;
    end
  end

  task automatic beat(input logic [PW-1:0] d, input logic last);
    int t = 0;
    pwr_valid = 1; pwr_data = d; pwr_last = last;
    while (!pwr_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) begin
      vecs++; errs++;
      $display("FAIL beat_timeout: pwr_ready stayed %0b, required 1", pwr_ready);
    end
    @(posedge clk); #1;
    pwr_valid = 0; pwr_last = 0;
  endtask

  task automatic frame(input int n, input logic [PW-1:0] d, input bit last_on_n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      beat(d, last_on_n && (i == n-1));
    end
  endtask

  task automatic get_result(output logic [AccW-1:0] r, output logic [AccW-1:0] m);
    int t = 0;
    while (got_q.size() == 0 && t < 300) begin @(posedge clk); #1; t++; end
    if (got_q.size() == 0) begin
      vecs++; errs++;
      $display("FAIL result_timeout: mel_valid=%0b, required a handshake", mel_valid);
      r = '0; m = '0;
    end else begin
      r = got_q.pop_front();
      m = mdl_q.pop_front();
    end
  endtask

  initial begin
    logic [AccW-1:0] r, m;
    int a0, f0, t;
    for (int i = 0; i < NB; i++) rom_mem[i] = 16'd1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // unit weights, unit power
    f0 = ferr_cnt;
    frame(16, 32'd1, 1, 0);
    get_result(r, m);
    chk("s1_result", r, 16); chk("s1_model", m, 16); chk("s1_ferr", ferr_cnt - f0, 0);

    // ramp weights, constant power, address sequence
    for (int i = 0; i < NB; i++) rom_mem[i] = CW'(i);
    a0 = addr_log.size();
    frame(16, 32'd2, 1, 0);
    get_result(r, m);
    chk("s2_result", r, 240); chk("s2_model", m, 240);
    for (int i = 0; i < NB; i++) chk("s2_addr", addr_log[a0+i], i);

    // downstream back-pressure
    for (int i = 0; i < NB; i++) rom_mem[i] = 16'd1;
    mel_ready = 0;
    frame(16, 32'd5, 1, 0);
    t = 0;
    while (!mel_valid && t < 50) begin @(posedge clk); #1; t++; end
    repeat (5) begin
      chk("s3_hold_ready", pwr_ready, 0);
      chk("s3_hold_valid", mel_valid, 1);
      chk("s3_hold_data", mel_data, 80);
      @(posedge clk); #1;
    end
    mel_ready = 1;
    get_result(r, m);
    chk("s3_result", r, 80); chk("s3_ready_after", pwr_ready, 1);

    // short frame: last on bin 9
    f0 = ferr_cnt;
    frame(10, 32'd3, 1, 0);
    get_result(r, m);
    chk("s4_result", r, 30); chk("s4_model", m, 30); chk("s4_ferr", ferr_cnt - f0, 1);
    chk("s4_next_addr", rom_addr, 0);

    // full frame with no last marker
    f0 = ferr_cnt;
    frame(16, 32'd1, 0, 0);
    get_result(r, m);
    chk("s4b_result", r, 16); chk("s4b_ferr", ferr_cnt - f0, 1);

    // reset mid-frame, then a clean frame
    frame(7, 32'd9, 0, 0);
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    f0 = ferr_cnt;
    frame(16, 32'd1, 1, 1);
    get_result(r, m);
    chk("s5_result", r, 16); chk("s5_ferr", ferr_cnt - f0, 0);

    // full-scale operands with valid gaps
    for (int i = 0; i < NB; i++) rom_mem[i] = 16'hFFFF;
    frame(16, 32'hFFFF_FFFF, 1, 2);
    get_result(r, m);
    chk("s6_result", r, 56'h0F_FFEF_FFF0_0010); chk("s6_model", m, 56'h0F_FFEF_FFF0_0010);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end
endmodule
